game_controller: RTL and testbench

GAME_CONTROLLER -- requirements
Module: game_controller

---
 rtl/whack_pkg.sv | 25 ++
 rtl/game_controller_if.sv | 33 +++
 rtl/game_controller_lfsr8.sv | 28 ++
 rtl/game_controller.sv | 126 ++++++++++++
 tb/tb_game_controller.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/whack_pkg.sv
// Shared definitions for the whack-a-mole game controller.
//   NUM_HOLES   : number of holes / buttons / mole outputs
//   LFSR_SEED   : value the mole-position LFSR restarts from
//   SCORE_W     : width of round/score style counters
//   state_t     : game controller state encoding
//   hole_onehot : hole index -> one-hot mole vector
package whack_pkg;

   localparam int          NUM_HOLES = 4;
   localparam logic [7:0]  LFSR_SEED = 8'hA5;
   localparam int          SCORE_W   = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_GAP  = 2'd1,
      S_UP   = 2'd2,
      S_OVER = 2'd3
   } state_t;

   function automatic logic [NUM_HOLES-1:0] hole_onehot(input logic [1:0] idx);
      hole_onehot      = '0;
      hole_onehot[idx] = 1'b1;
   endfunction

endpackage

// File: rtl/game_controller_if.sv
// Player/score-side signal bundle of the game controller.
//   start        : start request (level, sampled each cycle)
//   btn          : debounced, synchronized buttons, one per hole
//   mole         : one-hot active mole, 0 when none
//   hit          : one-cycle pulse on a valid whack
//   enable_score : score gate, high only while a mole is up
//   game_active  : high while a game is running (GAP or UP)
//   game_over    : high once the last mole of a game is done
//   rounds_left  : moles remaining in the current game
// master = player/score side, slave = game_controller.
interface game_controller_if;
   import whack_pkg::*;

   logic                 start;
   logic [NUM_HOLES-1:0] btn;
   logic [NUM_HOLES-1:0] mole;
   logic                 hit;
   logic                 enable_score;
   logic                 game_active;
   logic                 game_over;
   logic [SCORE_W-1:0]   rounds_left;

   modport master (
      output start, btn,
      input  mole, hit, enable_score, game_active, game_over, rounds_left
   );

   modport slave (
      input  start, btn,
      output mole, hit, enable_score, game_active, game_over, rounds_left
   );

endinterface

// File: rtl/game_controller_lfsr8.sv
// 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, free-running.
//   clk   : system clock
//   reset : asynchronous active-low reset, loads LFSR_SEED
//   q     : current LFSR state
// The polynomial is maximal-length and the seed is non-zero, so the
// register never reaches the all-zero lock-up state.
module lfsr8
   import whack_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   output logic [7:0] q
);

   logic [7:0] r_q;
   logic       w_fb;

   // Taps 8,6,5,4 counted from 1 map to bits 7,5,4,3.
   assign w_fb = r_q[7] ^ r_q[5] ^ r_q[4] ^ r_q[3];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_q <= LFSR_SEED;
      else        r_q <= {r_q[6:0], w_fb};
   end

   assign q = r_q;

endmodule

// File: rtl/game_controller.sv
// Whack-a-mole game sequencer: IDLE -> (GAP -> UP) x NUM_ROUNDS -> OVER.
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : game_controller_if.slave (start/btn in; mole, hit,
//           enable_score, game_active, game_over, rounds_left out)
// Parameters: UP_CYCLES (mole visible), GAP_CYCLES (pause between
// moles), NUM_ROUNDS (moles per game, 1..255). All outputs registered.
module game_controller
   import whack_pkg::*;
#(
   parameter int UP_CYCLES  = 50_000_000,
   parameter int GAP_CYCLES = 25_000_000,
   parameter int NUM_ROUNDS = 20
)(
   input  logic               clk,
   input  logic               reset,
   game_controller_if.slave   bus
);

   localparam int MAX_CYC = (UP_CYCLES > GAP_CYCLES) ? UP_CYCLES : GAP_CYCLES;
   localparam int TIMER_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [TIMER_W-1:0] UP_LOAD     = TIMER_W'(UP_CYCLES - 1);
   localparam logic [TIMER_W-1:0] GAP_LOAD    = TIMER_W'(GAP_CYCLES - 1);
   localparam logic [SCORE_W-1:0] ROUNDS_LOAD = SCORE_W'(NUM_ROUNDS);

   state_t               r_state,  w_state_nxt;
   logic [TIMER_W-1:0]   r_timer,  w_timer_nxt;
   logic [SCORE_W-1:0]   r_rounds, w_rounds_nxt;
   logic [NUM_HOLES-1:0] r_mole,   w_mole_nxt;
   logic                 r_hit,    w_hit_nxt;
   logic [NUM_HOLES-1:0] r_btn_q;
   logic                 r_enable_score;
   logic                 r_game_active;
   logic                 r_game_over;

   logic [7:0]           w_lfsr;
   logic                 w_unused_lfsr;
   logic [NUM_HOLES-1:0] w_btn_rise;
   logic                 w_whack;

   lfsr8 u_lfsr (
      .clk   (clk),
      .reset (reset),
      .q     (w_lfsr)
   );

   // Only the two low bits pick the hole.
   assign w_unused_lfsr = ^w_lfsr[7:2];

   // Rising edges only, so a held button never scores twice; any rising
   // edge on the lit hole counts as a single whack.
   assign w_btn_rise = bus.btn & ~r_btn_q;
   assign w_whack    = |(w_btn_rise & r_mole);

   always_comb begin
      w_state_nxt  = r_state;
      w_timer_nxt  = r_timer;
      w_rounds_nxt = r_rounds;
      w_mole_nxt   = r_mole;
      w_hit_nxt    = 1'b0;
      case (r_state)
         S_IDLE, S_OVER: begin
            if (bus.start) begin
               w_state_nxt  = S_GAP;
               w_rounds_nxt = ROUNDS_LOAD;
               w_timer_nxt  = GAP_LOAD;
            end
         end
         S_GAP: begin
            if (r_timer == '0) begin
               w_state_nxt = S_UP;
               w_timer_nxt = UP_LOAD;
               w_mole_nxt  = hole_onehot(w_lfsr[1:0]);
            end else begin
               w_timer_nxt = r_timer - TIMER_W'(1);
            end
         end
         S_UP: begin
            // A whack on the last visible cycle still wins over expiry.
            if (w_whack || (r_timer == '0)) begin
               w_hit_nxt    = w_whack;
               w_mole_nxt   = '0;
               w_rounds_nxt = r_rounds - SCORE_W'(1);
               w_timer_nxt  = GAP_LOAD;
               w_state_nxt  = (r_rounds == SCORE_W'(1)) ? S_OVER : S_GAP;
            end else begin
               w_timer_nxt = r_timer - TIMER_W'(1);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state        <= S_IDLE;
         r_timer        <= '0;
         r_rounds       <= '0;
         r_mole         <= '0;
         r_hit          <= 1'b0;
         r_btn_q        <= '0;
         r_enable_score <= 1'b0;
         r_game_active  <= 1'b0;
         r_game_over    <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_timer        <= w_timer_nxt;
         r_rounds       <= w_rounds_nxt;
         r_mole         <= w_mole_nxt;
         r_hit          <= w_hit_nxt;
         r_btn_q        <= bus.btn;
         r_enable_score <= (w_state_nxt == S_UP);
         r_game_active  <= (w_state_nxt == S_GAP) || (w_state_nxt == S_UP);
         r_game_over    <= (w_state_nxt == S_OVER);
      end
   end

   assign bus.mole         = r_mole;
   assign bus.hit          = r_hit;
   assign bus.enable_score = r_enable_score;
   assign bus.game_active  = r_game_active;
   assign bus.game_over    = r_game_over;
   assign bus.rounds_left  = r_rounds;

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller with short timings (UP=8, GAP=4, 3 rounds).
// A game-level reference model (phase, cycles left in phase, rounds,
// score) predicts every output each cycle.
module tb_game_controller;

   localparam int UP = 8;
   localparam int GAP = 4;
   localparam int NR = 3;

   typedef enum int {P_IDLE, P_GAP, P_UP, P_OVER} phase_e;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   game_controller_if gc_if ();

   game_controller #(
      .UP_CYCLES  (UP),
      .GAP_CYCLES (GAP),
      .NUM_ROUNDS (NR)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (gc_if.slave)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state
   phase_e     m_phase;
   int         m_left;
   int         m_rounds;
   logic [3:0] m_mole;
   logic [3:0] m_prev_btn;
   logic       m_hit;
   logic [7:0] m_lfsr;
   int         score_exp = 0;
   int         score_dut = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] lfsr_adv(input logic [7:0] l);
      return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
   endfunction

   task automatic model_reset();
      m_phase    = P_IDLE;
      m_left     = 0;
      m_rounds   = 0;
      m_mole     = '0;
      m_prev_btn = '0;
      m_hit      = 1'b0;
      m_lfsr     = 8'hA5;
   endtask

   task automatic end_round(input logic whacked);
      m_hit  = whacked;
      if (whacked) score_exp++;
      m_mole = '0;
      m_rounds--;
      if (m_rounds == 0) m_phase = P_OVER;
      else begin
         m_phase = P_GAP;
         m_left  = GAP;
      end
   endtask

   task automatic model_step(input logic st, input logic [3:0] b);
      logic [3:0] rise;
      rise  = b & ~m_prev_btn;
      m_hit = 1'b0;
      case (m_phase)
         P_IDLE, P_OVER: begin
            if (st) begin
               m_phase  = P_GAP;
               m_left   = GAP;
               m_rounds = NR;
            end
         end
         P_GAP: begin
            m_left--;
            if (m_left == 0) begin
               m_phase = P_UP;
               m_left  = UP;
               m_mole  = 4'b0001 << m_lfsr[1:0];
            end
         end
         P_UP: begin
            if ((rise & m_mole) != 4'b0) end_round(1'b1);
            else begin
               m_left--;
               if (m_left == 0) end_round(1'b0);
            end
         end
         default: ;
      endcase
      m_prev_btn = b;
      m_lfsr     = lfsr_adv(m_lfsr);
   endtask

   task automatic check_outputs();
      if (gc_if.hit === 1'b1) score_dut++;
      check("mole",         32'(gc_if.mole),         32'(m_mole));
      check("hit",          32'(gc_if.hit),          32'(m_hit));
      check("enable_score", 32'(gc_if.enable_score), 32'(m_phase == P_UP));
      check("game_active",  32'(gc_if.game_active),  32'((m_phase == P_GAP) || (m_phase == P_UP)));
      check("game_over",    32'(gc_if.game_over),    32'(m_phase == P_OVER));
      check("rounds_left",  32'(gc_if.rounds_left),  32'(m_rounds));
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset) model_step(gc_if.start, gc_if.btn);
      #1;
      check_outputs();
   endtask

   task automatic wait_phase(input phase_e p, input int max_cycles);
      int n = 0;
      while (m_phase != p && n < max_cycles) begin
         tick();
         n++;
      end
      checks++;
      assert (m_phase == p) else begin
         errors++;
         $error("FAIL wait_phase: observed phase %0d expected %0d", m_phase, p);
      end
   endtask

   initial begin
      gc_if.start = 1'b0;
      gc_if.btn   = 4'b0;
      model_reset();

      // Reset state
      #2;
      check_outputs();
      repeat (3) tick();
      reset = 1'b1;
      tick();

      // Start: four mole-free gap cycles, then exactly one mole
      gc_if.start = 1'b1;
      tick();
      gc_if.start = 1'b0;
      check("start_rounds", 32'(gc_if.rounds_left), 32'd3);
      check("start_active", 32'(gc_if.game_active), 32'd1);
      repeat (3) tick();
      check("gap_no_mole", 32'(gc_if.mole), 32'd0);
      tick();
      check("one_mole", 32'($countones(gc_if.mole)), 32'd1);

      // Matching press two cycles into UP, then keep it held
      tick();
      tick();
      gc_if.btn = m_mole;
      tick();
      check("whack_hit", 32'(gc_if.hit), 32'd1);
      check("whack_rounds", 32'(gc_if.rounds_left), 32'd2);
      tick();
      check("whack_hit_once", 32'(gc_if.hit), 32'd0);
      check("whack_mole_clear", 32'(gc_if.mole), 32'd0);

      // Next mole: held button plus edges only on other holes -> expiry
      wait_phase(P_UP, 20);
      gc_if.btn = gc_if.btn | ~m_mole;
      repeat (UP) tick();
      check("expire_rounds", 32'(gc_if.rounds_left), 32'd1);
      check("expire_mole", 32'(gc_if.mole), 32'd0);
      check("expire_score", 32'(score_dut), 32'd1);
      gc_if.btn = 4'b0;

      // Last mole: matching edge on the final UP cycle
      wait_phase(P_UP, 20);
      for (int n = 0; n < 20 && m_left > 1; n++) tick();
      gc_if.btn = m_mole;
      tick();
      check("final_cycle_hit", 32'(gc_if.hit), 32'd1);
      check("final_cycle_rounds", 32'(gc_if.rounds_left), 32'd0);
      check("final_cycle_over", 32'(gc_if.game_over), 32'd1);
      tick();
      check("final_cycle_hit_once", 32'(gc_if.hit), 32'd0);
      gc_if.btn = 4'b0;

      // Second game: three moles expire unwhacked
      gc_if.start = 1'b1;
      tick();
      gc_if.start = 1'b0;
      wait_phase(P_OVER, 100);
      check("over_flag", 32'(gc_if.game_over), 32'd1);
      check("over_enable", 32'(gc_if.enable_score), 32'd0);
      check("over_mole", 32'(gc_if.mole), 32'd0);
      check("over_score", 32'(score_dut), 32'd2);
      gc_if.start = 1'b1;
      tick();
      gc_if.start = 1'b0;
      check("restart_rounds", 32'(gc_if.rounds_left), 32'd3);

      // Randomized play, including start requests in every phase
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) gc_if.btn = 4'($urandom_range(0, 15));
         gc_if.start = ($urandom_range(0, 29) == 0);
         tick();
      end
      gc_if.start = 1'b0;
      gc_if.btn   = 4'b0;

      // Asynchronous reset in the middle of UP
      if (m_phase == P_IDLE || m_phase == P_OVER) begin
         gc_if.start = 1'b1;
         tick();
         gc_if.start = 1'b0;
      end
      wait_phase(P_UP, 40);
      tick();
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      check_outputs();
      gc_if.start = 1'b1;
      tick();
      tick();
      reset = 1'b1;
      tick();
      gc_if.start = 1'b0;
      check("post_reset_start", 32'(gc_if.rounds_left), 32'd3);
      repeat (5) tick();

      check("score_total", 32'(score_dut), 32'(score_exp));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
